// File: rtl/ldst_memc_responder_pkg.sv
// Shared types and defaults for the LD/ST memory-controller responder.
package ldst_memc_responder_pkg;

  localparam int unsigned DefaultAddrWidth = 24;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned MinRdLat         = 1;
  localparam int unsigned MaxRdLat         = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitDma = 2'd1,
    StGranted = 2'd2,
    StDrain   = 2'd3
  } memc_state_e;

endpackage

// File: rtl/ldst_rd_tracker.sv
// Tracks reads in flight: a valid shift register aligned to bank data, plus an
// outstanding counter that frees a slot when the response leaves the block.
module ldst_rd_tracker
  import ldst_memc_responder_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CntWidth       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset_poweron,
  input  logic                i_rd_accept,
  output logic                o_rd_capture,
  output logic                o_rd_return,
  output logic [CntWidth-1:0] o_outstanding
);

  // One extra stage covers the registered bank strobe ahead of the bank latency.
  logic [MEM_RD_LAT:0]  r_shift;
  logic                 r_return;
  logic [CntWidth-1:0]  r_outstanding;

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_shift       <= '0;
      r_return      <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_shift  <= {r_shift[MEM_RD_LAT-1:0], i_rd_accept};
      r_return <= r_shift[MEM_RD_LAT];
      unique case ({i_rd_accept, r_return})
        2'b10:   r_outstanding <= r_outstanding + CntWidth'(1);
        2'b01:   r_outstanding <= r_outstanding - CntWidth'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign o_rd_capture  = r_shift[MEM_RD_LAT];
  assign o_rd_return   = r_return;
  assign o_outstanding = r_outstanding;

endmodule

// File: rtl/ldst_memc_responder.sv
// Memory-controller side of the SIMD LD/ST port: arbitrates the bank against DMA,
// registers bank strobes and returns read data a fixed latency later, in order.
module ldst_memc_responder
  import ldst_memc_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefaultDataWidth,
  parameter int unsigned MEM_RD_LAT      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  ldst__memc__request,
  input  logic                  ldst__memc__released,
  input  logic                  ldst__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__write_address,
  input  logic [DATA_WIDTH-1:0] ldst__memc__write_data,
  input  logic                  ldst__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__read_address,
  input  logic                  dma__memc__busy,
  output logic                  memc__ldst__granted,
  output logic                  memc__ldst__write_ready,
  output logic                  memc__ldst__read_ready,
  output logic [DATA_WIDTH-1:0] memc__ldst__read_data,
  output logic                  memc__ldst__read_data_valid,
  output logic                  memc__ldst__dma_hold,
  output logic                  memc__mem__enable,
  output logic                  memc__mem__write,
  output logic [ADDR_WIDTH-1:0] memc__mem__address,
  output logic [DATA_WIDTH-1:0] memc__mem__write_data,
  input  logic [DATA_WIDTH-1:0] mem__memc__read_data
);

  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

  memc_state_e           r_state, w_state_next;
  logic                  r_granted;
  logic                  w_wr_accept, w_rd_accept, w_read_ready;
  logic                  w_rd_capture, w_rd_return;
  logic [CntWidth-1:0]   w_outstanding;
  logic                  r_mem_en, r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (ldst__memc__request) w_state_next = dma__memc__busy ? StWaitDma : StGranted;
      end
      StWaitDma: begin
        if (!ldst__memc__request)  w_state_next = StIdle;
        else if (!dma__memc__busy) w_state_next = StGranted;
      end
      StGranted: begin
        if (ldst__memc__released) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_outstanding == '0) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Grant lags GRANTED entry by a cycle and drops the cycle after a release.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_state   <= StIdle;
      r_granted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_granted <= (r_state == StGranted) && (w_state_next == StGranted);
    end
  end

  assign w_wr_accept  = ldst__memc__write_valid && r_granted;
  assign w_read_ready = r_granted && !ldst__memc__write_valid &&
                        (w_outstanding < CntWidth'(MAX_OUTSTANDING));
  assign w_rd_accept  = ldst__memc__read_valid && w_read_ready;

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_wr_accept || w_rd_accept;
      r_mem_wr <= w_wr_accept;
      if (w_wr_accept) begin
        r_mem_addr  <= ldst__memc__write_address;
        r_mem_wdata <= ldst__memc__write_data;
      end else if (w_rd_accept) begin
        r_mem_addr  <= ldst__memc__read_address;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_rd_data <= '0;
    end else if (w_rd_capture) begin
      r_rd_data <= mem__memc__read_data;
    end
  end

  ldst_rd_tracker #(
    .MEM_RD_LAT      (MEM_RD_LAT),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_rd_tracker (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .i_rd_accept   (w_rd_accept),
    .o_rd_capture  (w_rd_capture),
    .o_rd_return   (w_rd_return),
    .o_outstanding (w_outstanding)
  );

  assign memc__ldst__granted         = r_granted;
  assign memc__ldst__write_ready     = r_granted;
  assign memc__ldst__read_ready      = w_read_ready;
  assign memc__ldst__read_data       = r_rd_data;
  assign memc__ldst__read_data_valid = w_rd_return;
  assign memc__ldst__dma_hold        = (r_state != StIdle);
  assign memc__mem__enable           = r_mem_en;
  assign memc__mem__write            = r_mem_wr;
  assign memc__mem__address          = r_mem_addr;
  assign memc__mem__write_data       = r_mem_wdata;

endmodule
